// File: rtl/multicycle_control.sv
// Purpose: Moore-style sequencer for the multicycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Latency: one state per clock; lw 5, sw/R-type/addi 4, beq/j 3 cycles with memory always ready.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low (unless WAIT_MEM=0).
module multicycle_control #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e state_q, state_d;
    logic   mem_rdy;
    logic   pcwrite;
    logic   branch;
    logic   funct_ok;

    // With WAIT_MEM cleared every memory access is assumed to complete in one cycle.
    assign mem_rdy = (!WAIT_MEM) || mem_ready;

    // Only the five supported R-type functions are legal.
    assign funct_ok = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                      (funct == 6'b100101) || (funct == 6'b101010);

    // State register; reset drops straight to IDLE so all enables fall immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and output decode from the current state plus the few live inputs.
    always_comb begin
        state_d    = state_q;
        alucontrol = 3'b010;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is examined.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Corrupted encoding: everything quiet, resume at FETCH.
                alucontrol = 3'b000;
                state_d    = S_FETCH;
            end
        endcase
        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg;
    logic [1:0] pcsrc;
    logic       pcen, instr_done, illegal_op;

    logic       rst2_n;
    logic [2:0] alucontrol2;
    logic       alusrca2;
    logic [1:0] alusrcb2;
    logic       iord2, irwrite2, memwrite2, regwrite2, regdst2, memtoreg2;
    logic [1:0] pcsrc2;
    logic       pcen2, instr_done2, illegal_op2;

    logic [16:0] got, got2;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.WAIT_MEM(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .pcsrc(pcsrc), .pcen(pcen), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    // Second instance with memory waits disabled and mem_ready held low.
    multicycle_control #(.WAIT_MEM(1'b0)) u_nowait (
        .clk(clk), .rst_n(rst2_n), .op(op), .funct(funct), .zero(zero), .mem_ready(1'b0),
        .alucontrol(alucontrol2), .alusrca(alusrca2), .alusrcb(alusrcb2), .iord(iord2),
        .irwrite(irwrite2), .memwrite(memwrite2), .regwrite(regwrite2), .regdst(regdst2),
        .memtoreg(memtoreg2), .pcsrc(pcsrc2), .pcen(pcen2), .instr_done(instr_done2),
        .illegal_op(illegal_op2)
    );

    assign got  = {alucontrol, alusrca, alusrcb, iord, irwrite, memwrite, regwrite, regdst,
                   memtoreg, pcsrc, pcen, instr_done, illegal_op};
    assign got2 = {alucontrol2, alusrca2, alusrcb2, iord2, irwrite2, memwrite2, regwrite2,
                   regdst2, memtoreg2, pcsrc2, pcen2, instr_done2, illegal_op2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [16:0] ex(input logic [2:0] alu, input logic sa, input logic [1:0] sb,
                                       input logic io, input logic irw, input logic mw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic [1:0] ps, input logic pe, input logic dn,
                                       input logic il);
        return {alu, sa, sb, io, irw, mw, rw, rd, m2r, ps, pe, dn, il};
    endfunction

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic m,
                       input logic [16:0] e);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.mr = m; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    logic [16:0] e_idle, e_f1, e_f0, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr0, e_mwr1;
    logic [16:0] e_awb, e_br1, e_br0, e_aex, e_iwb, e_jmp;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;

    initial begin
        //            alu    sa sb    io irw mw rw rd m2r ps    pe dn il
        e_idle = ex(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        e_f1   = ex(3'b010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        e_f0   = ex(3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        e_dec  = ex(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        e_ill  = ex(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        e_madr = ex(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        e_mrd  = ex(3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        e_mwb  = ex(3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 1, 0);
        e_mwr0 = ex(3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        e_mwr1 = ex(3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 1, 0);
        e_awb  = ex(3'b010, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0, 1, 0);
        e_br1  = ex(3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0);
        e_br0  = ex(3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 0);
        e_aex  = ex(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        e_iwb  = ex(3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0);
        e_jmp  = ex(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0);

        // R-type sub: FETCH, DECODE, EXECUTE, ALUWB (done on 4th cycle)
        add(RT, 6'b100010, 0, 1, e_f1);
        add(RT, 6'b100010, 0, 1, e_dec);
        add(RT, 6'b100010, 0, 1, ex(3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        add(RT, 6'b100010, 0, 1, e_awb);
        // lw with three wait cycles in MEMRD
        add(LW, 6'b000000, 0, 1, e_f1);
        add(LW, 6'b000000, 0, 1, e_dec);
        add(LW, 6'b000000, 0, 1, e_madr);
        add(LW, 6'b000000, 0, 0, e_mrd);
        add(LW, 6'b000000, 0, 0, e_mrd);
        add(LW, 6'b000000, 0, 0, e_mrd);
        add(LW, 6'b000000, 0, 1, e_mrd);
        add(LW, 6'b000000, 0, 1, e_mwb);
        // beq taken, then a stalled fetch and beq not taken
        add(BEQ, 6'b000000, 1, 1, e_f1);
        add(BEQ, 6'b000000, 1, 1, e_dec);
        add(BEQ, 6'b000000, 1, 1, e_br1);
        add(BEQ, 6'b000000, 0, 0, e_f0);
        add(BEQ, 6'b000000, 0, 1, e_f1);
        add(BEQ, 6'b000000, 0, 1, e_dec);
        add(BEQ, 6'b000000, 0, 1, e_br0);
        // illegal opcode, then illegal R-type funct
        add(6'b111111, 6'b100000, 0, 1, e_f1);
        add(6'b111111, 6'b100000, 0, 1, e_ill);
        add(RT, 6'b000000, 0, 1, e_f1);
        add(RT, 6'b000000, 0, 1, e_ill);
        // slt and or decoding
        add(RT, 6'b101010, 0, 1, e_f1);
        add(RT, 6'b101010, 0, 1, e_dec);
        add(RT, 6'b101010, 0, 1, ex(3'b111, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        add(RT, 6'b101010, 0, 1, e_awb);
        add(RT, 6'b100101, 0, 1, e_f1);
        add(RT, 6'b100101, 0, 1, e_dec);
        add(RT, 6'b100101, 0, 1, ex(3'b001, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        add(RT, 6'b100101, 0, 1, e_awb);
        add(RT, 6'b100100, 0, 1, e_f1);
        add(RT, 6'b100100, 0, 1, e_dec);
        add(RT, 6'b100100, 0, 1, ex(3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        add(RT, 6'b100100, 0, 1, e_awb);
        // jump, then back-to-back addi
        add(JMP, 6'b000000, 0, 1, e_f1);
        add(JMP, 6'b000000, 0, 1, e_dec);
        add(JMP, 6'b000000, 0, 1, e_jmp);
        for (int k = 0; k < 2; k++) begin
            add(ADDI, 6'b000000, 0, 1, e_f1);
            add(ADDI, 6'b000000, 0, 1, e_dec);
            add(ADDI, 6'b000000, 0, 1, e_aex);
            add(ADDI, 6'b000000, 0, 1, e_iwb);
        end
        // sw with one wait cycle, then a second sw that gets reset in MEMWR
        add(SW, 6'b000000, 0, 1, e_f1);
        add(SW, 6'b000000, 0, 1, e_dec);
        add(SW, 6'b000000, 0, 1, e_madr);
        add(SW, 6'b000000, 0, 0, e_mwr0);
        add(SW, 6'b000000, 0, 1, e_mwr1);
        add(SW, 6'b000000, 0, 1, e_f1);
        add(SW, 6'b000000, 0, 1, e_dec);
        add(SW, 6'b000000, 0, 1, e_madr);
        add(SW, 6'b000000, 0, 0, e_mwr0);

        rst_n = 1'b0; rst2_n = 1'b0;
        op = RT; funct = 6'b100010; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset_idle", got, e_idle);
        rst_n = 1'b1;
        #1 check("idle_after_release", got, e_idle);

        foreach (tbl[i]) begin
            @(negedge clk);
            op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero; mem_ready = tbl[i].mr;
            #1 check($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Asynchronous reset while MEMWR is waiting on memory.
        #2 rst_n = 1'b0;
        #1 check("rst_in_memwr", got, e_idle);
        @(negedge clk);
        #1 check("rst_held", got, e_idle);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1 check("rst_release_idle", got, e_idle);
        @(negedge clk);
        #1 check("fetch_after_release", got, e_f1);

        // WAIT_MEM=0: lw completes in 5 cycles with mem_ready tied low.
        op = LW; funct = 6'b000000;
        rst2_n = 1'b1;
        #1 check("nw_idle", got2, e_idle);
        @(negedge clk); #1 check("nw_fetch", got2, e_f1);
        @(negedge clk); #1 check("nw_decode", got2, e_dec);
        @(negedge clk); #1 check("nw_memadr", got2, e_madr);
        @(negedge clk); #1 check("nw_memrd", got2, e_mrd);
        @(negedge clk); #1 check("nw_memwb", got2, e_mwb);
        @(negedge clk); #1 check("nw_fetch2", got2, e_f1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
